// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port, r0 tied to zero,
// plus a multi-cycle sweep clear of r1..NREGS-1. Optional macro REGFILE_BYPASS_EN adds write-to-read forwarding.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | normal operation; writes accepted, clr_req starts a sweep
// ST_SWEEP | clearing rf[idx] each edge; writes and clr_req ignored
module regfile_param #(
   parameter int XLEN = 32,
   parameter int AW   = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            clr_req,
   output logic            clr_busy
);

   localparam int NREGS = 2 ** AW;
   localparam logic [AW-1:0] IDX_FIRST = AW'(1);
   localparam logic [AW-1:0] IDX_LAST  = AW'(NREGS - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [AW-1:0]   idx;
   logic [AW-1:0]   idx_nxt;
   logic            busy_nxt;
   logic            wr_en;
   logic            clr_en;
   logic [XLEN-1:0] rf [NREGS];
   logic [XLEN-1:0] arr1;
   logic [XLEN-1:0] arr2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= IDX_FIRST;
         clr_busy <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         clr_busy <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      busy_nxt  = clr_busy;
      wr_en     = 1'b0;
      clr_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            // a write on the accept edge still lands; the sweep clears it later
            wr_en = we && (wa != '0);
            if (clr_req) begin
               state_nxt = ST_SWEEP;
               idx_nxt   = IDX_FIRST;
               busy_nxt  = 1'b1;
            end
         end
         ST_SWEEP: begin
            clr_en = 1'b1;
            if (idx == IDX_LAST) begin
               state_nxt = ST_IDLE;
               idx_nxt   = IDX_FIRST;
               busy_nxt  = 1'b0;
            end else begin
               idx_nxt = idx + IDX_FIRST;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            idx_nxt   = IDX_FIRST;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            rf[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            rf[wa] <= wd;
         end
         if (clr_en) begin
            rf[idx] <= '0;
         end
      end
   end

   assign arr1 = (ra1 == '0) ? '0 : rf[ra1];
   assign arr2 = (ra2 == '0) ? '0 : rf[ra2];

`ifdef REGFILE_BYPASS_EN
   // wr_en already excludes r0 and the sweep, so forwarding inherits both exclusions
   assign rd1 = (wr_en && (ra1 == wa)) ? wd : arr1;
   assign rd2 = (wr_en && (ra2 == wa)) ? wd : arr2;
`else
   assign rd1 = arr1;
   assign rd2 = arr2;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench for regfile_param against a per-edge behavioural model.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [2:0]  wa;
   logic [31:0] wd;
   logic [2:0]  ra1;
   logic [2:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        clr_req;
   logic        clr_busy;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: array contents, busy flag, edges elapsed since sweep acceptance
   logic [31:0] mem [8];
   bit          m_busy;
   int          m_k;

   regfile_param #(.XLEN(32), .AW(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .ra1      (ra1),
      .ra2      (ra2),
      .rd1      (rd1),
      .rd2      (rd2),
      .clr_req  (clr_req),
      .clr_busy (clr_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [2:0] ra);
      logic [31:0] v;
      v = (ra == 3'd0) ? 32'd0 : mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (!m_busy && we && wa != 3'd0 && ra == wa) v = wd;
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mem[i] = 32'd0;
      m_busy = 1'b0;
      m_k    = 0;
   endtask

   // one clock: drive, check combinational reads before the edge, update model, check busy after
   task automatic cyc(input logic w, input logic [2:0] a, input logic [31:0] d,
                      input logic [2:0] r1, input logic [2:0] r2, input logic c);
      we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; clr_req = c;
      #1;
      chk("rd1", rd1, model_rd(r1));
      chk("rd2", rd2, model_rd(r2));
      @(posedge clk);
      if (!m_busy) begin
         if (w && a != 3'd0) mem[a] = d;
         if (c) begin
            m_busy = 1'b1;
            m_k    = 0;
         end
      end else begin
         m_k++;
         mem[m_k] = 32'd0;
         if (m_k == 7) m_busy = 1'b0;
      end
      #1;
      chk("clr_busy", {31'd0, clr_busy}, {31'd0, m_busy});
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("rst_busy", {31'd0, clr_busy}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i); ra2 = 3'(7 - i);
         #1;
         chk("rst_rd1", rd1, 32'd0);
         chk("rst_rd2", rd2, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int busy_hi;
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; clr_req = 1'b0;
      model_reset();
      #12;
      chk("reset_busy", {31'd0, clr_busy}, 32'd0);
      chk("reset_rd1", rd1, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // r0 protection and basic write/read
      cyc(1'b1, 3'd3, 32'hDEADBEEF, 3'd0, 3'd0, 1'b0);
      cyc(1'b1, 3'd0, 32'h12345678, 3'd3, 3'd0, 1'b0);
      cyc(1'b0, 3'd0, 32'h0, 3'd3, 3'd0, 1'b0);
      chk("r3_value", rd1, 32'hDEADBEEF);
      chk("r0_value", rd2, 32'd0);

      // bypass probe: same-cycle read of the register being written
      cyc(1'b1, 3'd4, 32'h0BADBEEF, 3'd4, 3'd4, 1'b0);
      cyc(1'b1, 3'd4, 32'hCAFEF00D, 3'd4, 3'd0, 1'b0);
      cyc(1'b0, 3'd0, 32'h0, 3'd4, 3'd0, 1'b0);

      // fill, then sweep with an accept-edge write to r6 and a blocked write to r5
      for (int k = 1; k < 8; k++) cyc(1'b1, 3'(k), 32'h11 * k, 3'd0, 3'd0, 1'b0);
      cyc(1'b1, 3'd6, 32'h77, 3'd3, 3'd6, 1'b1);
      for (int k = 1; k <= 7; k++) cyc(1'b1, 3'd5, 32'hAAAA5555, 3'd3, 3'd6, 1'b1);
      for (int k = 1; k < 8; k++) cyc(1'b0, 3'd0, 32'h0, 3'(k), 3'd5, 1'b0);
      chk("r5_after_sweep", rd2, 32'd0);

      // reset in the middle of a sweep
      for (int k = 1; k < 8; k++) cyc(1'b1, 3'(k), 32'h5A000000 | k, 3'd0, 3'd0, 1'b0);
      cyc(1'b0, 3'd0, 32'h0, 3'd7, 3'd2, 1'b1);
      for (int k = 0; k < 3; k++) cyc(1'b0, 3'd0, 32'h0, 3'd7, 3'd2, 1'b0);
      async_reset();

      // clr_req held for 20 cycles: 7 busy, 1 idle, 7 busy, 1 idle, 4 busy
      busy_hi = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(1'b0, 3'd0, 32'h0, 3'd1, 3'd7, 1'b1);
         if (clr_busy) busy_hi++;
      end
      chk("held_busy_count", 32'(busy_hi), 32'd18);
      for (int k = 0; k < 4; k++) cyc(1'b0, 3'd0, 32'h0, 3'd1, 3'd7, 1'b0);

      // randomised traffic
      for (int n = 0; n < 400; n++) begin
         cyc(1'($urandom_range(0, 3) != 0), 3'($urandom), $urandom,
             3'($urandom), 3'($urandom), ($urandom_range(0, 15) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
